// File: rtl/div_pkg.sv
// Shared definitions for the divider control slice: FSM states and the
// default divider geometry.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_ITERS   = 33;
  localparam int DIV_TIMEOUT = 40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_HOLD
  } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Bundles the three links around the sequencer: operand intake, the
// iterative divider, and the result consumer.
interface div_sequencer_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;

  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_clr;
  logic             div_ready;
  logic [WIDTH-1:0] div_result;
  logic             div_exception;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic             out_div0;
  logic             out_timeout;

  // The sequencer itself.
  modport slave (
    input  in_valid, in_dividend, in_divisor,
    input  div_ready, div_result, div_exception,
    input  out_ready,
    output in_ready,
    output div_dividend, div_divisor, div_clr,
    output out_valid, out_quotient, out_div0, out_timeout
  );

  // The surroundings: producer, divider and consumer.
  modport master (
    output in_valid, in_dividend, in_divisor,
    output div_ready, div_result, div_exception,
    output out_ready,
    input  in_ready,
    input  div_dividend, div_divisor, div_clr,
    input  out_valid, out_quotient, out_div0, out_timeout
  );

endinterface

// File: rtl/run_counter.sv
// Free-standing up-counter with synchronous active-low reset, a synchronous
// zero-load and a count enable; zero-load wins over enable.
module run_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_zero,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!clr) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Control stage in front of the iterative signed divider: accepts one operand
// pair, runs the divider once, and holds the quotient and flags for the consumer.
module div_sequencer import div_pkg::*; #(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int TIMEOUT = DIV_TIMEOUT,
  parameter int CNT_W   = 6
) (
  input  logic            clk,
  input  logic            clr,
  div_sequencer_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] run_count;

  logic accept;
  logic capture_div;
  logic capture_to;
  logic cnt_zero;
  logic cnt_en;

  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quotient_q;
  logic             div0_q;
  logic             timeout_q;

  run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk       (clk),
    .clr       (clr),
    .load_zero (cnt_zero),
    .en        (cnt_en),
    .count     (run_count)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    capture_div = 1'b0;
    capture_to  = 1'b0;
    cnt_zero    = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_zero   = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        cnt_en = 1'b1;
        // A divider result in the last allowed cycle still beats the timeout.
        if (bus.div_ready) begin
          capture_div = 1'b1;
          state_next  = S_HOLD;
        end else if (run_count == CNT_W'(TIMEOUT - 1)) begin
          capture_to = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
      div0_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (accept) begin
        dividend_q <= bus.in_dividend;
        divisor_q  <= bus.in_divisor;
      end
      if (capture_div) begin
        quotient_q <= bus.div_exception ? '0 : bus.div_result;
        div0_q     <= bus.div_exception;
        timeout_q  <= 1'b0;
      end else if (capture_to) begin
        quotient_q <= '0;
        div0_q     <= 1'b0;
        timeout_q  <= 1'b1;
      end
    end
  end

  // Handshake outputs decode registered state only, keeping valid/ready
  // free of combinational paths from the opposite side.
  assign bus.in_ready     = (state == S_IDLE);
  assign bus.out_valid    = (state == S_HOLD);
  assign bus.div_clr      = (state != S_RUN);
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.out_quotient = quotient_q;
  assign bus.out_div0     = div0_q;
  assign bus.out_timeout  = timeout_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural 33-iteration divider
// stub that can be muted to provoke the timeout path.
module tb_div_sequencer;
  import div_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic stub_en = 1'b1;
  logic [5:0] stub_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32), .TIMEOUT(40), .CNT_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  function automatic logic [31:0] stub_quot(input logic signed [31:0] a,
                                            input logic signed [31:0] b);
    if (b == 0) return 32'hDEAD_BEEF;
    return a / b;
  endfunction

  // Divider stub: counter held at zero by div_clr, result pulse on iteration 33.
  always @(posedge clk) begin
    if (bus.div_clr) stub_cnt <= '0;
    else             stub_cnt <= stub_cnt + 1'b1;
  end

  assign bus.div_ready     = stub_en && !bus.div_clr && (stub_cnt == 6'(DIV_ITERS));
  assign bus.div_result    = stub_quot(bus.div_dividend, bus.div_divisor);
  assign bus.div_exception = (bus.div_divisor == 32'd0);

  task automatic launch(input logic [31:0] dd, input logic [31:0] dv, input bit keep);
    bus.in_valid    = 1'b1;
    bus.in_dividend = dd;
    bus.in_divisor  = dv;
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid, bounded; an expired bound is a failure.
  task automatic wait_for_valid(input string name, output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (bus.out_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s no out_valid within %0d edges", name, edges);
    end
  endtask

  task automatic test_reset();
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b1;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.div_clr !== 1'b1) begin bad++; $display("FAIL reset_div_clr got=%b exp=1", bus.div_clr); end
    total++; if (bus.out_quotient !== 32'd0) begin bad++; $display("FAIL reset_quot got=%h exp=0", bus.out_quotient); end
    total++; if ({bus.out_div0, bus.out_timeout} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {bus.out_div0, bus.out_timeout}); end
    total++; if (bus.div_dividend !== 32'd0) begin bad++; $display("FAIL reset_dividend got=%h exp=0", bus.div_dividend); end
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b exp=1", bus.in_ready); end
    launch(32'd100, 32'd7, 1'b0);
    wait_for_valid("basic", lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL basic_latency got=%0d exp=35", lat); end
    total++; if (bus.out_quotient !== 32'h0000_000E) begin bad++; $display("FAIL basic_quot got=%h exp=0000000e", bus.out_quotient); end
    total++; if ({bus.out_div0, bus.out_timeout} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b exp=00", {bus.out_div0, bus.out_timeout}); end
    total++; if (bus.div_divisor !== 32'd7) begin bad++; $display("FAIL basic_divisor got=%h exp=7", bus.div_divisor); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_release got=%b%b exp=01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(-32'sd100, 32'd7, 1'b1);
    // Next job already offered while the first is in flight; it must wait.
    bus.in_dividend = 32'd7;
    bus.in_divisor  = 32'hFFFF_FFFF;
    wait_for_valid("b2b_first", lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=35", lat); end
    total++; if (bus.out_quotient !== 32'hFFFF_FFF2) begin bad++; $display("FAIL b2b_first_quot got=%h exp=fffffff2", bus.out_quotient); end
    total++; if (bus.div_dividend !== 32'hFFFF_FF9C) begin bad++; $display("FAIL b2b_operand_hold got=%h exp=ffffff9c", bus.div_dividend); end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_for_valid("b2b_second", lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=35", lat); end
    total++; if (bus.out_quotient !== 32'hFFFF_FFF9) begin bad++; $display("FAIL b2b_second_quot got=%h exp=fffffff9", bus.out_quotient); end
    @(negedge clk);
  endtask

  task automatic test_div0();
    int lat;
    launch(32'd5, 32'd0, 1'b0);
    wait_for_valid("div0", lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL div0_latency got=%0d exp=35", lat); end
    total++; if (bus.out_div0 !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b exp=1", bus.out_div0); end
    total++; if (bus.out_quotient !== 32'd0) begin bad++; $display("FAIL div0_quot got=%h exp=0", bus.out_quotient); end
    total++; if (bus.out_timeout !== 1'b0) begin bad++; $display("FAIL div0_timeout got=%b exp=0", bus.out_timeout); end
    @(negedge clk);
  endtask

  task automatic test_hold_stall();
    int lat;
    bit stable = 1'b1;
    bus.out_ready = 1'b0;
    launch(32'd1000, 32'hFFFF_FFF6, 1'b0);
    wait_for_valid("stall", lat);
    total++; if (bus.out_quotient !== 32'hFFFF_FF9C) begin bad++; $display("FAIL stall_quot got=%h exp=ffffff9c", bus.out_quotient); end
    bus.in_valid    = 1'b1;
    bus.in_dividend = 32'd1;
    bus.in_divisor  = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_quotient !== 32'hFFFF_FF9C || bus.div_dividend !== 32'd1000) stable = 1'b0;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_stable got=%b exp=1", stable); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b%b exp=01", bus.out_valid, bus.in_ready); end
    total++; if (bus.div_dividend !== 32'd1000) begin bad++; $display("FAIL stall_ignored_job got=%h exp=000003e8", bus.div_dividend); end
  endtask

  task automatic test_timeout();
    int lat;
    stub_en = 1'b0;
    launch(32'd9, 32'd3, 1'b0);
    wait_for_valid("timeout", lat);
    total++; if (lat !== 41) begin bad++; $display("FAIL timeout_latency got=%0d exp=41", lat); end
    total++; if (bus.out_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1", bus.out_timeout); end
    total++; if (bus.out_quotient !== 32'd0 || bus.out_div0 !== 1'b0) begin bad++; $display("FAIL timeout_result got=%h/%b exp=0/0", bus.out_quotient, bus.out_div0); end
    @(negedge clk);
    stub_en = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit quiet = 1'b1;
    launch(32'd50, 32'd5, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (bus.div_clr !== 1'b0) begin bad++; $display("FAIL midrst_in_run got=%b exp=0", bus.div_clr); end
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    total++; if (bus.out_valid !== 1'b0 || bus.div_clr !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_state got=%b%b%b exp=011", bus.out_valid, bus.div_clr, bus.in_ready); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL midrst_discard got=%b exp=1", quiet); end
    launch(32'd50, 32'd5, 1'b0);
    wait_for_valid("midrst_next", lat);
    total++; if (lat !== 35) begin bad++; $display("FAIL midrst_latency got=%0d exp=35", lat); end
    total++; if (bus.out_quotient !== 32'd10) begin bad++; $display("FAIL midrst_quot got=%h exp=0000000a", bus.out_quotient); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div0();
    test_hold_stall();
    test_timeout();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
